// File: rtl/atm_pkg.sv
// Shared definitions for the ATM transaction scheduler: op codes, FSM state
// encoding, account-count default and an id-width helper.
package atm_pkg;

    localparam int unsigned N_ACC_DEFAULT = 10;

    typedef enum logic [1:0] {
        OP_BALANCE  = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_TRANSFER = 2'b10,
        OP_RESERVED = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdSrc,
        StChkSrc,
        StRdDst,
        StChkDst,
        StWrSrc,
        StWrDst,
        StResp
    } state_e;

    // Width of a terminal index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atm_txn_scheduler_if.sv
// Terminal request/response and balance-RAM signals of the scheduler.
// The slave modport is the scheduler side; master is the terminals plus RAM.
interface atm_txn_scheduler_if
    import atm_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned BAL_W = 16,
    parameter int unsigned AMT_W = 11
);
    localparam int unsigned ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [2*N_REQ-1:0]     req_op;
    logic [IDX_W*N_REQ-1:0] req_src;
    logic [IDX_W*N_REQ-1:0] req_dst;
    logic [AMT_W*N_REQ-1:0] req_amt;
    logic [N_REQ-1:0]       req_ready;

    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_error;
    logic [BAL_W-1:0]       rsp_balance;
    logic                   busy;

    logic                   mem_en;
    logic                   mem_we;
    logic [IDX_W-1:0]       mem_addr;
    logic [BAL_W-1:0]       mem_wdata;
    logic [BAL_W-1:0]       mem_rdata;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_amt, mem_rdata,
        input  req_ready, rsp_valid, rsp_id, rsp_error, rsp_balance, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_amt, mem_rdata,
        output req_ready, rsp_valid, rsp_id, rsp_error, rsp_balance, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last accepted grant.
// The pointer only moves when the grant is actually accepted.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IdxW  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic             accept_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]  gnt_idx_o,
    output logic             gnt_vld_o
);
    logic [IdxW-1:0] last_q, last_d;

    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = (32'(last_q) + off) % N_REQ;
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_vld_o   = 1'b1;
                gnt_idx_o   = IdxW'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i && gnt_vld_o) begin
            last_d = gnt_idx_o;
        end
    end

    // Reset to the last slot so terminal 0 wins the first search.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= IdxW'(N_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/atm_txn_scheduler.sv
// Shares one single-port balance RAM between N_REQ terminals, running each
// accepted BALANCE/WITHDRAW/TRANSFER as an atomic read-modify-write sequence.
module atm_txn_scheduler
    import atm_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned N_ACC = N_ACC_DEFAULT,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned BAL_W = 16,
    parameter int unsigned AMT_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    atm_txn_scheduler_if.slave  bus
);
    localparam int unsigned ID_W = id_width(N_REQ);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [BAL_W-1:0] src_bal_q, src_bal_d;
    logic [BAL_W-1:0] dst_new_q, dst_new_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic [BAL_W-1:0] rsp_bal_q, rsp_bal_d;

    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             accept;

    op_e              sel_op;
    logic [IDX_W-1:0] sel_src, sel_dst;
    logic [AMT_W-1:0] sel_amt;
    logic             pre_err;

    logic [BAL_W-1:0] amt_ext;
    logic [BAL_W-1:0] src_new;
    logic [BAL_W:0]   dst_sum;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IdxW  (ID_W)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (bus.req_valid),
        .accept_i  (accept),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Payload of the terminal the arbiter currently selects.
    always_comb begin
        sel_op  = op_e'(bus.req_op[2*32'(gnt_idx) +: 2]);
        sel_src = bus.req_src[IDX_W*32'(gnt_idx) +: IDX_W];
        sel_dst = bus.req_dst[IDX_W*32'(gnt_idx) +: IDX_W];
        sel_amt = bus.req_amt[AMT_W*32'(gnt_idx) +: AMT_W];
        pre_err = (sel_op == OP_RESERVED) || (32'(sel_src) >= N_ACC) ||
                  ((sel_op == OP_TRANSFER) &&
                   ((32'(sel_dst) >= N_ACC) || (sel_dst == sel_src)));
    end

    assign amt_ext = BAL_W'(amt_q);
    assign src_new = src_bal_q - amt_ext;
    // Extra carry bit flags a destination balance that would overflow.
    assign dst_sum = {1'b0, bus.mem_rdata} + {1'b0, amt_ext};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        id_d      = id_q;
        src_d     = src_q;
        dst_d     = dst_q;
        amt_d     = amt_q;
        src_bal_d = src_bal_q;
        dst_new_d = dst_new_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;
        rsp_bal_d = rsp_bal_q;
        accept    = 1'b0;

        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (gnt_vld && rst_n) begin
                    accept = 1'b1;
                    op_d   = sel_op;
                    id_d   = gnt_idx;
                    src_d  = sel_src;
                    dst_d  = sel_dst;
                    amt_d  = sel_amt;
                    if (pre_err) begin
                        state_d   = StResp;
                        rsp_id_d  = gnt_idx;
                        rsp_err_d = 1'b1;
                        rsp_bal_d = '0;
                    end else begin
                        state_d = StRdSrc;
                    end
                end
            end
            StRdSrc: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = src_q;
                state_d      = StChkSrc;
            end
            StChkSrc: begin
                src_bal_d = bus.mem_rdata;
                if (op_q == OP_BALANCE) begin
                    state_d   = StResp;
                    rsp_id_d  = id_q;
                    rsp_err_d = 1'b0;
                    rsp_bal_d = bus.mem_rdata;
                end else if (amt_ext > bus.mem_rdata) begin
                    state_d   = StResp;
                    rsp_id_d  = id_q;
                    rsp_err_d = 1'b1;
                    rsp_bal_d = bus.mem_rdata;
                end else if (op_q == OP_WITHDRAW) begin
                    state_d = StWrSrc;
                end else begin
                    state_d = StRdDst;
                end
            end
            StRdDst: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = dst_q;
                state_d      = StChkDst;
            end
            StChkDst: begin
                if (dst_sum[BAL_W]) begin
                    state_d   = StResp;
                    rsp_id_d  = id_q;
                    rsp_err_d = 1'b1;
                    rsp_bal_d = src_bal_q;
                end else begin
                    dst_new_d = dst_sum[BAL_W-1:0];
                    state_d   = StWrSrc;
                end
            end
            StWrSrc: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = src_q;
                bus.mem_wdata = src_new;
                if (op_q == OP_TRANSFER) begin
                    state_d = StWrDst;
                end else begin
                    state_d   = StResp;
                    rsp_id_d  = id_q;
                    rsp_err_d = 1'b0;
                    rsp_bal_d = src_new;
                end
            end
            StWrDst: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = dst_q;
                bus.mem_wdata = dst_new_q;
                state_d       = StResp;
                rsp_id_d      = id_q;
                rsp_err_d     = 1'b0;
                rsp_bal_d     = src_new;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.req_ready   = accept ? gnt_oh : '0;
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_error   = rsp_err_q;
    assign bus.rsp_balance = rsp_bal_q;
    assign bus.busy        = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OP_BALANCE;
            id_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            amt_q     <= '0;
            src_bal_q <= '0;
            dst_new_q <= '0;
            rsp_id_q  <= '0;
            rsp_err_q <= 1'b0;
            rsp_bal_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            id_q      <= id_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            amt_q     <= amt_d;
            src_bal_q <= src_bal_d;
            dst_new_q <= dst_new_d;
            rsp_id_q  <= rsp_id_d;
            rsp_err_q <= rsp_err_d;
            rsp_bal_q <= rsp_bal_d;
        end
    end

endmodule

// File: tb/tb_atm_txn_scheduler.sv
// Bench for atm_txn_scheduler: ledger-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_atm_txn_scheduler;
    import atm_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned IW = 4;
    localparam int unsigned BW = 16;
    localparam int unsigned AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atm_txn_scheduler_if #(.N_REQ(NR), .IDX_W(IW), .BAL_W(BW), .AMT_W(AW)) bus ();

    atm_txn_scheduler #(
        .N_REQ (NR),
        .N_ACC (10),
        .IDX_W (IW),
        .BAL_W (BW),
        .AMT_W (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Balance RAM: one-cycle read latency.
    logic [BW-1:0] ram [16] = '{default: 16'd500};
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rst_edge = 1'b1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected event (cycle %0d)", name, cyc);
    endtask

    // Reference model: account ledger plus the expected RAM-access schedule.
    typedef struct {
        int            cyc;
        bit            we;
        logic [IW-1:0] addr;
        logic [BW-1:0] data;
    } acc_t;

    logic [BW-1:0] bal_m [16] = '{default: 16'd500};
    acc_t mq[$];
    bit pend = 1'b0;
    int acc_cyc = 0, rsp_cyc = 0, last_m = NR - 1;
    int exp_id = 0, exp_err = 0, exp_bal = 0;
    int hold_id = 0, hold_err = 0, hold_bal = 0;

    task automatic push_acc(input int c, input bit we, input int addr, input int data);
        acc_t a;
        a.cyc  = c;
        a.we   = we;
        a.addr = IW'(addr);
        a.data = BW'(data);
        mq.push_back(a);
    endtask

    task automatic model_accept(input int t);
        int op, src, dst, amt, sb, db, lat;
        op  = int'(bus.req_op[2*t +: 2]);
        src = int'(bus.req_src[IW*t +: IW]);
        dst = int'(bus.req_dst[IW*t +: IW]);
        amt = int'(bus.req_amt[AW*t +: AW]);
        sb  = int'(bal_m[src]);
        db  = int'(bal_m[dst]);
        acc_cyc = cyc;
        pend    = 1'b1;
        exp_id  = t;
        exp_err = 0;
        if (op == 3 || src >= 10 || (op == 2 && (dst >= 10 || dst == src))) begin
            lat = 1; exp_err = 1; exp_bal = 0;
        end else begin
            push_acc(cyc + 1, 1'b0, src, 0);
            if (op == 0) begin
                lat = 3; exp_bal = sb;
            end else if (amt > sb) begin
                lat = 3; exp_err = 1; exp_bal = sb;
            end else if (op == 1) begin
                push_acc(cyc + 3, 1'b1, src, sb - amt);
                lat = 4; exp_bal = sb - amt;
            end else begin
                push_acc(cyc + 3, 1'b0, dst, 0);
                if (db + amt > 65535) begin
                    lat = 5; exp_err = 1; exp_bal = sb;
                end else begin
                    push_acc(cyc + 5, 1'b1, src, sb - amt);
                    push_acc(cyc + 6, 1'b1, dst, db + amt);
                    lat = 7; exp_bal = sb - amt;
                end
            end
        end
        rsp_cyc = cyc + lat;
    endtask

    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        bit e_en, e_we;
        logic [IW-1:0] e_addr;
        logic [BW-1:0] e_data;
        acc_t cur;
        int g, i;
        if (rst_edge) begin
            pend = 1'b0;
            mq.delete();
            hold_id = 0; hold_err = 0; hold_bal = 0;
            last_m = NR - 1;
        end
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
        if (mq.size() > 0 && mq[0].cyc == cyc) begin
            cur = mq.pop_front();
            e_en = 1'b1; e_we = cur.we; e_addr = cur.addr; e_data = cur.data;
        end
        if (pend && cyc == rsp_cyc) begin
            hold_id = exp_id; hold_err = exp_err; hold_bal = exp_bal;
        end
        exp_rdy = '0;
        g = -1;
        if (!pend && rst_n) begin
            for (int k = 1; k <= NR; k++) begin
                i = (last_m + k) % NR;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("busy", 32'(bus.busy), 32'(pend && cyc > acc_cyc));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(pend && cyc == rsp_cyc));
        check("rsp_id", 32'(bus.rsp_id), hold_id);
        check("rsp_error", 32'(bus.rsp_error), hold_err);
        check("rsp_balance", 32'(bus.rsp_balance), hold_bal);
        check("mem_en", 32'(bus.mem_en), 32'(e_en));
        check("mem_we", 32'(bus.mem_we), 32'(e_we));
        if (e_en) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_we) begin
            check("mem_wdata", 32'(bus.mem_wdata), 32'(e_data));
            bal_m[e_addr] = e_data;
        end
        if (pend && cyc == rsp_cyc) pend = 1'b0;
        if (g >= 0) begin
            last_m = g;
            model_accept(g);
        end
    end

    task automatic set_req(input int t, input int op, input int src, input int dst,
                           input int amt);
        bus.req_op[2*t +: 2]    = 2'(op);
        bus.req_src[IW*t +: IW] = IW'(src);
        bus.req_dst[IW*t +: IW] = IW'(dst);
        bus.req_amt[AW*t +: AW] = AW'(amt);
    endtask

    task automatic issue(input int t, input int op, input int src, input int dst,
                         input int amt, output int lat, output int id, output int err,
                         output int bal);
        bit got;
        int acc;
        lat = -1; id = -1; err = -1; bal = -1; acc = 0; got = 1'b0;
        set_req(t, op, src, dst, amt);
        bus.req_valid[t] = 1'b1;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[t]) begin got = 1'b1; acc = cyc; end
        end
        @(posedge clk);
        #1 bus.req_valid[t] = 1'b0;
        if (!got) begin
            fail_now("accept_wait");
        end else begin
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge clk);
                if (bus.rsp_valid) begin
                    got = 1'b1;
                    lat = cyc - acc;
                    id  = int'(bus.rsp_id);
                    err = int'(bus.rsp_error);
                    bal = int'(bus.rsp_balance);
                end
            end
            if (!got) fail_now("rsp_wait");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        if (!done) fail_now("idle_wait");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, id, err, bal, ng, acc;
        int g[4];
        bit got;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_amt   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain balance query.
        issue(0, 0, 0, 0, 0, lat, id, err, bal);
        check("t1_latency", lat, 3);
        check("t1_error", err, 0);
        check("t1_balance", bal, 500);

        // Withdraw that fits, then one that overdraws.
        issue(0, 1, 3, 0, 200, lat, id, err, bal);
        check("t2a_latency", lat, 4);
        check("t2a_balance", bal, 300);
        check("t2a_ram3", 32'(ram[3]), 300);
        issue(0, 1, 3, 0, 600, lat, id, err, bal);
        check("t2b_latency", lat, 3);
        check("t2b_error", err, 1);
        check("t2b_balance", bal, 300);
        check("t2b_ram3", 32'(ram[3]), 300);

        // Transfer from terminal 1.
        issue(1, 2, 1, 2, 100, lat, id, err, bal);
        check("t3_latency", lat, 7);
        check("t3_id", id, 1);
        check("t3_error", err, 0);
        check("t3_balance", bal, 400);
        check("t3_ram1", 32'(ram[1]), 400);
        check("t3_ram2", 32'(ram[2]), 600);

        // Both terminals requesting continuously must alternate.
        g = '{-1, -1, -1, -1};
        ng = 0;
        set_req(0, 0, 7, 0, 0);
        set_req(1, 0, 8, 0, 0);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g[ng] = bus.req_ready[1] ? 1 : 0;
                ng++;
            end
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        check("t4_grants", ng, 4);
        check("t4_grant0", g[0], 0);
        check("t4_grant1", g[1], 1);
        check("t4_grant2", g[2], 0);
        check("t4_grant3", g[3], 1);
        wait_idle();

        // Pre-check rejects: self-transfer and out-of-range account.
        issue(0, 2, 4, 4, 50, lat, id, err, bal);
        check("t5a_latency", lat, 1);
        check("t5a_error", err, 1);
        check("t5a_balance", bal, 0);
        issue(1, 1, 12, 0, 10, lat, id, err, bal);
        check("t5b_latency", lat, 1);
        check("t5b_id", id, 1);
        check("t5b_error", err, 1);
        check("t5b_balance", bal, 0);

        // Reset while the transfer sits in CHK_DST.
        set_req(0, 2, 5, 6, 50);
        bus.req_valid[0] = 1'b1;
        got = 1'b0;
        acc = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[0]) begin got = 1'b1; acc = cyc; end
        end
        if (!got) fail_now("t6_accept_wait");
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        check("t6_cycle_at_reset", cyc, acc + 4);
        @(posedge clk);
        @(negedge clk);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 0);
        check("t6_rsp_id", 32'(bus.rsp_id), 0);
        check("t6_rsp_error", 32'(bus.rsp_error), 0);
        check("t6_mem_en", 32'(bus.mem_en), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 1, 0, 0);
        bus.req_valid = 2'b11;
        ng = -1;
        for (int k = 0; k < 30 && ng < 0; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) ng = bus.req_ready[1] ? 1 : 0;
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        check("t6_first_grant", ng, 0);
        wait_idle();
        check("t6_ram5", 32'(ram[5]), 500);
        check("t6_ram6", 32'(ram[6]), 500);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
